// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan driver.
// Glyphs are active-low, bit 0 = segment a ... bit 6 = segment g.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] GLYPH_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

  function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble);
    return GLYPH_TBL[nibble];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble to active-low glyph, forced dark by blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  // blank wins over the glyph lookup
  assign seg = blank ? SEG_OFF : seg7_glyph(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode display scanner with
// frame-synchronous word updates, ghost blanking and a global on/off.
// Optional build macro SEG7_LZ_BLANK_EN enables leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 4
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [4*NUM_DIGITS-1:0] iDATA,
  input  logic [NUM_DIGITS-1:0]   iDP,
  input  logic                    iLOAD,
  input  logic                    iON_OFF,
  output logic [6:0]              oSEG,
  output logic                    oDP,
  output logic [NUM_DIGITS-1:0]   oAN,
  output logic                    oFRAME,
  output logic                    oPEND
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_TC    = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           pre;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] disp_data, pend_data;
  logic [NUM_DIGITS-1:0]   disp_dp, pend_dp;
  logic                    pend;
  logic                    pre_tc, boundary, dark, lz_blank;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;

  assign pre_tc   = (pre == PRE_TC);
  assign boundary = pre_tc && (idx == IDX_LAST);
  // ghost blanking at the start of each slot, or global off
  assign dark     = (pre < PRE_BLANK) || !iON_OFF;
  assign oPEND    = pend;

  // slot prescaler and digit index
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pre <= '0;
      idx <= '0;
    end else if (pre_tc) begin
      pre <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // pending/displayed word; a load in the boundary cycle bypasses pending
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pend_data <= '0;
      pend_dp   <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
      pend      <= 1'b0;
    end else begin
      if (iLOAD) begin
        pend_data <= iDATA;
        pend_dp   <= iDP;
      end
      if (boundary) begin
        pend <= 1'b0;
        if (iLOAD) begin
          disp_data <= iDATA;
          disp_dp   <= iDP;
        end else if (pend) begin
          disp_data <= pend_data;
          disp_dp   <= pend_dp;
        end
      end else if (iLOAD) begin
        pend <= 1'b1;
      end
    end
  end

  // select the nibble and decimal point of the active digit
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib = disp_data[4*k +: 4];
        cur_dp  = disp_dp[k];
      end
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  lz_run;

  // digit k>0 is a leading zero when it and all higher nibbles are zero
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run     = lz_run && (disp_data[4*k +: 4] == 4'h0);
      lz_mask[k] = lz_run;
    end
  end

  // leading-zero flag of the active digit
  always_comb begin
    lz_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) lz_blank = lz_mask[k];
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  seg7_decode u_decode (
    .nibble (cur_nib),
    .blank  (dark || lz_blank),
    .seg    (seg_nxt)
  );

  // one active-low anode for the current slot unless dark
  always_comb begin
    an_nxt = '1;
    if (!dark) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx == IW'(k)) an_nxt[k] = 1'b0;
      end
    end
  end

  // registered pin drivers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oSEG   <= SEG_OFF;
      oDP    <= 1'b1;
      oAN    <= '1;
      oFRAME <= 1'b0;
    end else begin
      oSEG   <= seg_nxt;
      oDP    <= dark || !cur_dp;
      oAN    <= an_nxt;
      oFRAME <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench for seg7_scan_driver with
// NUM_DIGITS=4, SCAN_DIV=16, BLANK_CYC=2. Honours SEG7_LZ_BLANK_EN.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        iRST, iLOAD, iON_OFF;
  logic [15:0] iDATA;
  logic [3:0]  iDP;
  logic [6:0]  oSEG;
  logic        oDP, oFRAME, oPEND;
  logic [3:0]  oAN;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int falls    = 0;
  logic prev_pend = 1'b0;

`ifdef SEG7_LZ_BLANK_EN
  localparam logic [6:0] ZERO_HI = 7'h7F;
`else
  localparam logic [6:0] ZERO_HI = 7'h40;
`endif

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(16), .BLANK_CYC(2)) dut (
    .iCLK    (clk),
    .iRST    (iRST),
    .iDATA   (iDATA),
    .iDP     (iDP),
    .iLOAD   (iLOAD),
    .iON_OFF (iON_OFF),
    .oSEG    (oSEG),
    .oDP     (oDP),
    .oAN     (oAN),
    .oFRAME  (oFRAME),
    .oPEND   (oPEND)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_pend && !oPEND) falls++;
    prev_pend = oPEND;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp);
    iLOAD = 1'b1;
    iDATA = d;
    iDP   = dp;
    tick();
    iLOAD = 1'b0;
  endtask

  initial begin
    int lit [4];
    int frames;
    int f0;

    iRST = 1'b1; iLOAD = 1'b0; iON_OFF = 1'b1; iDATA = '0; iDP = '0;
    tick(); tick(); tick();
    iRST = 1'b0;
    cyc  = 0;
    chk("rst_an",    32'(oAN),    32'hF);
    chk("rst_seg",   32'(oSEG),   32'h7F);
    chk("rst_dp",    32'(oDP),    32'h1);
    chk("rst_frame", 32'(oFRAME), 32'h0);
    chk("rst_pend",  32'(oPEND),  32'h0);

    // idle first frame: scan order, lit time, single frame pulse
    lit = '{0, 0, 0, 0};
    frames = 0;
    repeat (64) begin
      tick();
      for (int k = 0; k < 4; k++) if (oAN == ~(4'b0001 << k)) lit[k]++;
      if (oFRAME) frames++;
      if (cyc == 1)  chk("idle_an_c1", 32'(oAN), 32'hF);
      if (cyc == 2)  chk("idle_seg_blank", 32'(oSEG), 32'h7F);
      if (cyc == 3)  begin
        chk("idle_an0",  32'(oAN),  32'b1110);
        chk("idle_seg0", 32'(oSEG), 32'h40);
        chk("idle_dp0",  32'(oDP),  32'h1);
      end
      if (cyc == 16) chk("idle_an0_end", 32'(oAN), 32'b1110);
      if (cyc == 17) chk("idle_ghost",   32'(oAN), 32'hF);
      if (cyc == 19) begin
        chk("idle_an1",  32'(oAN),  32'b1101);
        chk("idle_seg1", 32'(oSEG), 32'(ZERO_HI));
      end
      if (cyc == 63) chk("idle_frame_c63", 32'(oFRAME), 32'h0);
      if (cyc == 64) begin
        chk("idle_frame_c64", 32'(oFRAME), 32'h1);
        chk("idle_an3",       32'(oAN),    32'b0111);
      end
    end
    for (int k = 0; k < 4; k++) chk($sformatf("lit_cycles_%0d", k), 32'(lit[k]), 32'd14);
    chk("frame_count", 32'(frames), 32'd1);
    run_to(127); chk("frame_c127", 32'(oFRAME), 32'h0);
    run_to(128); chk("frame_c128", 32'(oFRAME), 32'h1);

    // mid-frame load waits for the boundary
    run_to(140); load(16'h1A2F, 4'b0100);
    chk("ld1_pend", 32'(oPEND), 32'h1);
    run_to(180);
    chk("ld1_old_seg", 32'(oSEG), 32'(ZERO_HI));
    chk("ld1_old_dp",  32'(oDP),  32'h1);
    run_to(191); chk("ld1_pend_c191", 32'(oPEND), 32'h1);
    run_to(192);
    chk("ld1_pend_fall", 32'(oPEND),  32'h0);
    chk("ld1_frame",     32'(oFRAME), 32'h1);
    run_to(194); chk("ld1_ghost", 32'(oAN), 32'hF);
    run_to(195);
    chk("ld1_an0", 32'(oAN), 32'b1110); chk("ld1_seg0", 32'(oSEG), 32'h0E); chk("ld1_dp0", 32'(oDP), 32'h1);
    run_to(211);
    chk("ld1_an1", 32'(oAN), 32'b1101); chk("ld1_seg1", 32'(oSEG), 32'h24); chk("ld1_dp1", 32'(oDP), 32'h1);
    run_to(227);
    chk("ld1_an2", 32'(oAN), 32'b1011); chk("ld1_seg2", 32'(oSEG), 32'h08); chk("ld1_dp2", 32'(oDP), 32'h0);
    run_to(243);
    chk("ld1_an3", 32'(oAN), 32'b0111); chk("ld1_seg3", 32'(oSEG), 32'h79); chk("ld1_dp3", 32'(oDP), 32'h1);

    // two loads in one frame: last one wins, one falling edge of oPEND
    run_to(260);
    f0 = falls;
    load(16'h1111, 4'b0000);
    chk("ld2_pend_a", 32'(oPEND), 32'h1);
    run_to(280); load(16'h2222, 4'b0000);
    chk("ld2_pend_b", 32'(oPEND), 32'h1);
    run_to(319); chk("ld2_pend_c319", 32'(oPEND), 32'h1);
    run_to(320);
    chk("ld2_pend_fall", 32'(oPEND),  32'h0);
    chk("ld2_frame",     32'(oFRAME), 32'h1);
    run_to(323); chk("ld2_an0", 32'(oAN), 32'b1110); chk("ld2_seg0", 32'(oSEG), 32'h24);
    run_to(330); chk("ld2_falls", 32'(falls - f0), 32'd1);
    run_to(371); chk("ld2_an3", 32'(oAN), 32'b0111); chk("ld2_seg3", 32'(oSEG), 32'h24);

    // load exactly in the boundary cycle goes straight to display
    run_to(383); load(16'h0042, 4'b0000);
    chk("ldb_pend",  32'(oPEND),  32'h0);
    chk("ldb_frame", 32'(oFRAME), 32'h1);
    run_to(385); chk("ldb_pend_c385", 32'(oPEND), 32'h0);
    run_to(387); chk("ldb_an0", 32'(oAN), 32'b1110); chk("ldb_seg0", 32'(oSEG), 32'h24);
    run_to(403); chk("ldb_an1", 32'(oAN), 32'b1101); chk("ldb_seg1", 32'(oSEG), 32'h19);
    run_to(419); chk("ldb_an2", 32'(oAN), 32'b1011); chk("ldb_seg2", 32'(oSEG), 32'(ZERO_HI));
    run_to(435); chk("ldb_an3", 32'(oAN), 32'b0111); chk("ldb_seg3", 32'(oSEG), 32'(ZERO_HI));

    // display off for 40 cycles with a load inside the window
    run_to(440);
    iON_OFF = 1'b0;
    while (cyc < 480) begin
      tick();
      if (cyc == 451) begin
        iLOAD = 1'b0;
        chk("off_pend", 32'(oPEND), 32'h1);
      end
      chk("off_an",  32'(oAN),  32'hF);
      chk("off_seg", 32'(oSEG), 32'h7F);
      chk("off_dp",  32'(oDP),  32'h1);
      if (cyc == 447 || cyc == 448) chk($sformatf("off_frame_c%0d", cyc), 32'(oFRAME), (cyc == 448) ? 32'h1 : 32'h0);
      if (cyc == 450) begin
        iLOAD = 1'b1; iDATA = 16'h0005; iDP = 4'b0000;
      end
    end
    iON_OFF = 1'b1;
    run_to(483); chk("on_an2", 32'(oAN), 32'b1011); chk("on_seg2", 32'(oSEG), 32'(ZERO_HI));
    run_to(512); chk("on_pend", 32'(oPEND), 32'h0); chk("on_frame", 32'(oFRAME), 32'h1);
    run_to(515); chk("on_an0", 32'(oAN), 32'b1110); chk("on_seg0", 32'(oSEG), 32'h12);

    // reset while a word is pending discards it
    run_to(520); load(16'h7777, 4'hF);
    chk("rp_pend", 32'(oPEND), 32'h1);
    run_to(531); chk("rp_an1", 32'(oAN), 32'b1101); chk("rp_seg1", 32'(oSEG), 32'(ZERO_HI));
    run_to(540);
    iRST = 1'b1;
    tick(); tick();
    iRST = 1'b0;
    cyc  = 0;
    chk("rp_rst_pend", 32'(oPEND), 32'h0);
    chk("rp_rst_an",   32'(oAN),   32'hF);
    chk("rp_rst_seg",  32'(oSEG),  32'h7F);
    run_to(1);  chk("rp_rel_pend", 32'(oPEND), 32'h0); chk("rp_rel_an", 32'(oAN), 32'hF);
    run_to(3);  chk("rp_an0", 32'(oAN), 32'b1110); chk("rp_seg0", 32'(oSEG), 32'h40); chk("rp_dp0", 32'(oDP), 32'h1);
    run_to(19); chk("rp_seg1_post", 32'(oSEG), 32'(ZERO_HI));
    run_to(63); chk("rp_frame_c63", 32'(oFRAME), 32'h0);
    run_to(64); chk("rp_frame_c64", 32'(oFRAME), 32'h1); chk("rp_pend_c64", 32'(oPEND), 32'h0);
    run_to(67); chk("rp_seg0_after", 32'(oSEG), 32'h40); chk("rp_dp0_after", 32'(oDP), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed multi-digit seven-segment display driver. Latches a packed hex word and scans it across `NUM_DIGITS` common-anode digits, one digit per time slot. It adds tear-free frame-synchronous updates, inter-digit ghost blanking, per-digit decimal points and a global on/off. It sits between the LCD/axis datapath logic and the board's shared segment and anode pins.

## Interface

Parameters:
- `NUM_DIGITS`, default 4: number of scanned digits, range 1–8.
- `SCAN_DIV`, default 50000: clock cycles per digit slot, minimum 8.
- `BLANK_CYC`, default 4: cycles at the start of each slot with all anodes off. Must be less than `SCAN_DIV`.

Ports:
- `iCLK`, in, 1: system clock.
- `iRST`, in, 1: reset. Synchronous and active-high.
- `iDATA`, in, 4*NUM_DIGITS: packed hex nibbles. Digit k is `iDATA[4k+3:4k]`, and digit 0 is the rightmost.
- `iDP`, in, NUM_DIGITS: decimal point request per digit, 1 = lit. Latched together with `iDATA`.
- `iLOAD`, in, 1: single-cycle strobe that captures `iDATA` and `iDP`.
- `iON_OFF`, in, 1: 0 forces the display dark.
- `oSEG`, out, 7: segments, active-low. `oSEG[0]`=a … `oSEG[6]`=g.
- `oDP`, out, 1: decimal point, active-low.
- `oAN`, out, NUM_DIGITS: anode enables, active-low.
- `oFRAME`, out, 1: one-cycle pulse at the start of every frame.
- `oPEND`, out, 1: high while a captured word waits for the next frame boundary.

## Operation

Counters:
- A prescaler `pre` counts 0..SCAN_DIV-1.
- When `pre` reaches its terminal count, the digit index `idx` advances 0→1→…→NUM_DIGITS-1→0.

Registers:
- `pend_r` is the pending word (data plus DP).
- `disp_r` is the displayed word.

Load handling:
- `iLOAD` writes `pend_r` and sets `oPEND`.
- A second `iLOAD` while `oPEND` is high overwrites `pend_r`; only the last word is kept.

Frame boundary:
- The boundary is the cycle where `idx` wraps to 0, i.e. `pre` is at terminal count and `idx`=NUM_DIGITS-1.
- At the boundary, if `oPEND` is set, `disp_r` ← `pend_r` and `oPEND` clears.
- If `iLOAD` occurs in the same boundary cycle, `iDATA`/`iDP` go straight into `disp_r` and `oPEND` ends low.

Segment decode uses the standard hex glyph set, active-low. Examples: 0=7'h40, 1=7'h79, 2=7'h24, 8=7'h00, A=7'h08, F=7'h0E.

Output selection:
- For slot `idx`, while `pre` < BLANK_CYC: `oAN` is all ones and `oSEG`/`oDP` are all ones.
- Otherwise: `oAN[idx]`=0 and all other anode bits are 1. `oSEG` is the glyph of nibble `idx` of `disp_r`, and `oDP` = ~`disp_r` DP[`idx`].

`iON_OFF`=0 forces `oAN`, `oSEG` and `oDP` to all ones. Scanning, loading and `oFRAME` continue unaffected.

## Timing

- Reset values: `pre`=0, `idx`=0, `disp_r`=0, `pend_r`=0, `oPEND`=0, `oFRAME`=0, `oAN`=all ones, `oSEG`=7'h7F, `oDP`=1.
- Reset held mid-frame aborts the frame and discards any pending word.
- `oSEG`, `oDP`, `oAN` and `oFRAME` are registered. They reflect `pre`/`idx`/`disp_r`/`iON_OFF` from the previous cycle, giving 1-cycle latency.
- `oFRAME` is high in the first cycle of a frame, i.e. the cycle after the boundary.
- The first frame after reset produces no `oFRAME` pulse until the first wrap.
- Frame period is NUM_DIGITS*SCAN_DIV cycles. Each digit is lit for SCAN_DIV-BLANK_CYC cycles per frame.
- `oPEND` rises in the cycle after `iLOAD`. It falls in the cycle after the boundary, at the same time as `oFRAME`.
- Worst-case load-to-display delay is NUM_DIGITS*SCAN_DIV+2 cycles.
- With NUM_DIGITS=1, every slot wrap is a frame boundary.

## Configuration

- Macro: `SEG7_LZ_BLANK_EN`.
- Defined: leading-zero suppression. A digit k>0 is blanked (`oSEG`=7'h7F) when nibble k and every higher nibble of `disp_r` are 0.
  - Digit 0 is never blanked.
  - The anode still activates for a blanked digit, and `oDP` is still driven from DP[k].
- Undefined: every digit shows its glyph, including leading zeros.

## Structure

- Package `seg7_pkg` holds:
  - the 16-entry glyph constant table,
  - `SEG_OFF`=7'h7F,
  - the function `seg7_glyph(nibble)`.
- Index and prescaler widths use `$clog2(NUM_DIGITS)` and `$clog2(SCAN_DIV)`, minimum 1.
- One sub-module, `seg7_decode`: a combinational nibble→glyph decoder with a blank input. It is instantiated once, after the `idx` mux.

## Test plan

Run all scenarios with NUM_DIGITS=4, SCAN_DIV=16, BLANK_CYC=2.
- Reset, then idle for 64 cycles → anodes cycle 1110, 1101, 1011, 0111, each lit for 14 cycles. The lit digit shows 7'h40; blanked digits show 7'h7F when `SEG7_LZ_BLANK_EN` is defined. `oFRAME` pulses every 64 cycles.
- `iLOAD` with `iDATA`=16'h1A2F and `iDP`=4'b0100 mid-frame → `oPEND`=1 until the boundary. The next frame shows F, 2, A, 1 (7'h0E, 7'h24, 7'h08, 7'h79), with `oDP`=0 only on digit 2.
- Two loads in one frame (16'h1111, then 16'h2222) → only 2222 is displayed, and `oPEND` falls once.
- `iLOAD` of 16'h0042 exactly in the boundary cycle → `oPEND` stays 0. Digit 0 shows 2 in the new frame. Digits 2 and 3 are blank when the macro is defined, and show 0 when it is not.
- `iON_OFF`=0 for 40 cycles → `oAN`=4'hF and `oSEG`=7'h7F. `oFRAME` timing is unchanged, and a load during this window is applied normally.
- `iRST` asserted while `oPEND`=1 mid-frame → the cycle after reset release, `oPEND`=0, `oAN`=4'hF and `disp_r` is 0.
